// File: rtl/counter_pkg.sv
// Shared types and constants for the counter family.
package counter_pkg;

    // Behaviour at the ends of the counting range.
    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } cnt_mode_e;

    // Encoding of the up_dn input.
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage : counter_pkg

// File: rtl/stride_next_calc.sv
// Combinational next-count calculator for one stride step.
// Takes the already-clamped stride s (s <= limit) and produces the value the
// counter moves to plus a flag marking a boundary event (wrap, saturate, or
// recovery from a count that sits above a freshly lowered limit).
import counter_pkg::*;

module stride_next_calc #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] limit,
    input  logic             up_dn,
    input  cnt_mode_e        mode,
    output logic [WIDTH-1:0] next_count,
    output logic             boundary
);

    // One extra bit so count+s and limit+1 never truncate, even at full range.
    logic [WIDTH:0] sum_up;
    logic [WIDTH:0] modulus;
    logic [WIDTH:0] wrap_up;
    logic [WIDTH:0] wrap_dn;

    assign sum_up  = {1'b0, count} + {1'b0, s};
    assign modulus = {1'b0, limit} + {{WIDTH{1'b0}}, 1'b1};
    assign wrap_up = sum_up - modulus;
    assign wrap_dn = {1'b0, count} + modulus - {1'b0, s};

    // Select the next value: out-of-range guard first, then hold, then up/down.
    always_comb begin
        next_count = count;
        boundary   = 1'b0;
        if (count > limit) begin
            next_count = (up_dn == DIR_UP) ? '0 : limit;
            boundary   = 1'b1;
        end else if (s == '0) begin
            next_count = count;
            boundary   = 1'b0;
        end else if (up_dn == DIR_UP) begin
            if (sum_up <= {1'b0, limit}) begin
                next_count = sum_up[WIDTH-1:0];
            end else begin
                next_count = (mode == MODE_SAT) ? limit : wrap_up[WIDTH-1:0];
                boundary   = 1'b1;
            end
        end else begin
            if (count >= s) begin
                next_count = count - s;
            end else begin
                next_count = (mode == MODE_SAT) ? '0 : wrap_dn[WIDTH-1:0];
                boundary   = 1'b1;
            end
        end
    end

endmodule : stride_next_calc

// File: rtl/stride_counter.sv
// Programmable-stride up/down counter with programmable modulus,
// wrap/saturate mode, parallel load, terminal-count pulse and sticky
// boundary flag. The only flow control is en: a step happens on every
// edge where en=1 and neither rst nor load is asserted.
import counter_pkg::*;

module stride_counter #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             mode,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] stride;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] step_next;
    logic             step_boundary;

    // A stride larger than the range behaves like a full-range stride.
    assign stride       = (step > limit) ? limit : step;
    assign load_clamped = (load_val > limit) ? limit : load_val;

    stride_next_calc #(
        .WIDTH (WIDTH)
    ) u_next (
        .count      (count),
        .s          (stride),
        .limit      (limit),
        .up_dn      (up_dn),
        .mode       (cnt_mode_e'(mode)),
        .next_count (step_next),
        .boundary   (step_boundary)
    );

    // Priority rst > load > en > hold; tc pulses only after a boundary step.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= RST_VAL;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            tc    <= 1'b0;
        end else if (en) begin
            count <= step_next;
            tc    <= step_boundary;
            ovf   <= step_boundary | (ovf & ~clr_ovf);
        end else begin
            tc    <= 1'b0;
            ovf   <= ovf & ~clr_ovf;
        end
    end

endmodule : stride_counter

// File: tb/tb_stride_counter.sv
// Self-checking bench for stride_counter (WIDTH=4) with a behavioural model.
module tb_stride_counter;

    localparam int WIDTH = 4;
    localparam int RST   = 0;

    logic             clk;
    logic             rst;
    logic             en;
    logic             up_dn;
    logic             mode;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] limit;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clr_ovf;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;

    int n_assert;
    int n_fail;

    // reference model state (plain integers)
    int m_count;
    int m_tc;
    int m_ovf;

    stride_counter #(
        .WIDTH   (WIDTH),
        .RST_VAL (4'(RST))
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .mode     (mode),
        .step     (step),
        .limit    (limit),
        .load     (load),
        .load_val (load_val),
        .clr_ovf  (clr_ovf),
        .count    (count),
        .tc       (tc),
        .ovf      (ovf)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model one edge from the rules: clamp stride, compare against limit+1.
    task automatic model_edge();
        int lim, s, b;
        lim = int'(limit);
        b   = 0;
        if (rst) begin
            m_count = RST; m_tc = 0; m_ovf = 0;
        end else if (load) begin
            m_count = (int'(load_val) > lim) ? lim : int'(load_val);
            m_tc    = 0;
        end else if (en) begin
            s = (int'(step) > lim) ? lim : int'(step);
            if (m_count > lim) begin
                m_count = up_dn ? 0 : lim; b = 1;
            end else if (s == 0) begin
                b = 0;
            end else if (up_dn) begin
                if (m_count + s <= lim) m_count = m_count + s;
                else begin m_count = mode ? lim : m_count + s - (lim + 1); b = 1; end
            end else begin
                if (m_count >= s) m_count = m_count - s;
                else begin m_count = mode ? 0 : m_count + (lim + 1) - s; b = 1; end
            end
            m_tc  = b;
            m_ovf = (b != 0 || (m_ovf != 0 && !clr_ovf)) ? 1 : 0;
        end else begin
            m_tc  = 0;
            m_ovf = (m_ovf != 0 && !clr_ovf) ? 1 : 0;
        end
    endtask

    // driver: advance model and DUT one edge, then compare #1 after it
    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check({tag, "_count"}, 32'(count), 32'(m_count));
        check({tag, "_tc"},    32'(tc),    32'(m_tc));
        check({tag, "_ovf"},   32'(ovf),   32'(m_ovf));
    endtask

    task automatic idle();
        rst = 0; en = 0; load = 0; clr_ovf = 0;
    endtask

    initial begin
        logic [WIDTH-1:0] seq2 [7];
        n_assert = 0; n_fail = 0;
        m_count = 0; m_tc = 0; m_ovf = 0;
        seq2 = '{4'd3, 4'd6, 4'd9, 4'd2, 4'd5, 4'd8, 4'd1};
        idle();
        up_dn = 1; mode = 0; step = 2; limit = 15; load_val = 0;

        // reset state
        rst = 1;
        tick("reset");
        tick("reset2");
        check("reset_const", 32'(count), 32'(RST));

        // wrap up, limit 15, step 2: full-range modulus
        rst = 0; en = 1;
        for (int i = 0; i < 10; i++) tick("wrap15");
        check("wrap15_ovf_after", 32'(ovf), 32'd1);

        // limit 9 step 3 wrap up from 0
        en = 0; load = 1; load_val = 0; limit = 9; step = 3;
        tick("ld0");
        load = 0; en = 1; clr_ovf = 1;
        for (int i = 0; i < 7; i++) begin
            tick("wrap9");
            check("wrap9_seq", 32'(count), 32'(seq2[i]));
            clr_ovf = 0;
        end

        // saturate up then down, limit 10 step 4
        en = 0; load = 1; load_val = 0; limit = 10; step = 4; mode = 1;
        tick("ld_sat");
        load = 0; en = 1;
        for (int i = 0; i < 5; i++) tick("sat_up");
        up_dn = 0;
        for (int i = 0; i < 4; i++) tick("sat_dn");

        // wrap down, limit 9 step 3 from 1; clamped load; load beats en
        mode = 0; en = 0; load = 1; load_val = 1; limit = 9; step = 3;
        tick("ld1");
        load = 0; en = 1;
        for (int i = 0; i < 4; i++) tick("wrap_dn");
        load = 1; load_val = 200 % 16; en = 1; // 8 fits; use 15 for clamp
        load_val = 15;
        tick("ld_clamp");
        check("ld_clamp_const", 32'(count), 32'd9);

        // limit lowered under count, set and clear same cycle
        load = 1; load_val = 12; limit = 15; up_dn = 1;
        tick("ld12");
        load = 0; limit = 5; en = 1; clr_ovf = 1;
        tick("guard");
        check("guard_count", 32'(count), 32'd0);
        check("guard_ovf", 32'(ovf), 32'd1);
        en = 0;
        tick("clr_only");
        check("clr_only_ovf", 32'(ovf), 32'd0);

        // reset beats load mid-count; zero stride holds
        clr_ovf = 0; limit = 15; load = 1; load_val = 7;
        tick("ld7");
        rst = 1; load = 1; load_val = 3;
        tick("rst_load");
        rst = 0; load = 0; en = 1; step = 0; load_val = 7;
        load = 1; tick("ld7b"); load = 0;
        tick("hold0");
        check("hold0_const", 32'(count), 32'd7);

        // randomized stimulus against the model
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 49) == 0);
            load     = ($urandom_range(0, 9) == 0);
            en       = ($urandom_range(0, 3) != 0);
            up_dn    = 1'($urandom_range(0, 1));
            mode     = 1'($urandom_range(0, 1));
            step     = 4'($urandom_range(0, 15));
            limit    = 4'($urandom_range(0, 15));
            load_val = 4'($urandom_range(0, 15));
            clr_ovf  = load ? 1'b0 : ($urandom_range(0, 7) == 0);
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_stride_counter
